// File: rtl/branch_seq.sv
// Multicycle branch sequencer: target compute, compare, condition eval, conditional PC write.
// Drives the condition evaluator and keeps a saturating count of taken branches.
module branch_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             branch_taken,
    output logic             target_load,
    output logic             alu_cmp,
    output logic             UC_control,
    output logic [1:0]       UC_op,
    output logic             pc_write,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TARGET  = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_EVAL    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_ILL     = 3'd5;

    logic [2:0]       state;
    logic [1:0]       op_q;
    logic             taken_q;
    logic [CNT_W-1:0] cnt_q;

    // Holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Branch opcodes 0x04..0x07 map directly onto their low two bits.
    function automatic logic is_branch(input logic [5:0] op);
        return op[5:2] == 4'b0001;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            op_q    <= 2'b00;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_branch(opcode)) begin
                            op_q  <= opcode[1:0];
                            state <= S_TARGET;
                        end else begin
                            state <= S_ILL;
                        end
                    end
                end
                S_TARGET:  state <= S_COMPARE;
                S_COMPARE: state <= S_EVAL;
                S_EVAL: begin
                    taken_q <= branch_taken;
                    if (branch_taken)
                        cnt_q <= sat_inc(cnt_q);
                    state <= S_WRITE;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        target_load = 1'b0;
        alu_cmp     = 1'b0;
        UC_control  = 1'b0;
        pc_write    = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_TARGET:  target_load = 1'b1;
            S_COMPARE: alu_cmp     = 1'b1;
            S_EVAL:    UC_control  = 1'b1;
            S_WRITE: begin
                pc_write = taken_q;
                done     = 1'b1;
            end
            S_ILL: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign UC_op       = op_q;
    assign busy        = (state != S_IDLE);
    assign taken_count = cnt_q;

endmodule
